data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory_pkg.sv | 17 +
 rtl/data_memory.sv | 44 ++++
 tb/tb_data_memory.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_pkg
// Purpose  : Shared default widths and word type for the data memory block.
// Revision : 1.0 - initial release
// ============================================================================
package data_memory_pkg;

  // Default geometry: 32 words of 32 bits
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // One storage word at the default width
  typedef logic [DATA_W-1:0] word_t;

endpackage : data_memory_pkg
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module   : data_memory
// Purpose  : Register-based word memory with a combinational read port, a
//            synchronous write port sharing one address, and an asynchronous
//            active-low clear of every word.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory #(
  parameter int DATA_W = data_memory_pkg::DATA_W,
  parameter int ADDR_W = data_memory_pkg::ADDR_W
) (
  input  logic              Clock,
  input  logic              R,
  input  logic              WriteEn,
  input  logic [ADDR_W-1:0] Addy,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData
);

  import data_memory_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  // Flops rather than a RAM macro, so the whole array can be cleared at once
  logic [DATA_W-1:0] mem [DEPTH];

  // Storage: reset clears every word without a clock edge; otherwise an
  // enabled rising edge loads only the addressed word
  always_ff @(posedge Clock or negedge R) begin
    if (!R) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (WriteEn) begin
      mem[Addy] <= WriteData;
    end
  end

  // Read port: pure mux on the address, zero-cycle latency
  assign ReadData = mem[Addy];

endmodule : data_memory
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory
// Purpose  : Directed self-checking bench for data_memory with a reference
//            word array and an expected-value queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory;

  import data_memory_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        write_en;
  logic [4:0]  addy;
  word_t       write_data;
  word_t       read_data;

  word_t       model [32];
  word_t       sb [$];
  int          total;
  int          bad;

  data_memory #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .Clock    (clk),
    .R        (rst_n),
    .WriteEn  (write_en),
    .Addy     (addy),
    .WriteData(write_data),
    .ReadData (read_data)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Pop the oldest expectation and compare it with the read port
  task automatic check(input string tag);
    word_t exp;
    exp = sb.pop_front();
    total++;
    assert (read_data === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, read_data, exp);
    end
  endtask

  // Present an address, queue the model's word, compare after settling
  task automatic read_chk(input logic [4:0] a, input string tag);
    addy = a;
    sb.push_back(model[a]);
    #1;
    check(tag);
  endtask

  // Sweep all addresses against the model
  task automatic sweep(input string tag);
    for (int a = 0; a < 32; a++) begin
      read_chk(5'(a), tag);
    end
  endtask

  // Enabled write: old data visible before the edge, new data right after
  task automatic write_chk(input logic [4:0] a, input word_t d, input string tag);
    @(negedge clk);
    addy       = a;
    write_data = d;
    write_en   = 1'b1;
    sb.push_back(model[a]);
    #1;
    check({tag, "_before_edge"});
    @(posedge clk);
    model[a] = d;
    sb.push_back(model[a]);
    #1;
    check({tag, "_after_edge"});
    write_en = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    write_en   = 1'b0;
    addy       = '0;
    write_data = '0;
    model_clear();

    // Reset: every address reads zero
    #2;
    sweep("reset_sweep");

    // Writes ignored while reset is held, even with the enable set
    @(negedge clk);
    addy       = 5'd3;
    write_data = 32'hFFFF_FFFF;
    write_en   = 1'b1;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_chk(5'd3, "write_in_reset");

    // Release reset between edges; first write on the next enabled edge
    @(negedge clk);
    rst_n = 1'b1;

    // Fill: word n holds n
    for (int n = 0; n < 32; n++) begin
      write_chk(5'(n), word_t'(n), "fill");
    end
    sweep("fill_sweep");

    // Extremes stored bit-exact, neighbours untouched
    write_chk(5'd1, 32'h7FFF_FFFF, "max_pos");
    write_chk(5'd0, 32'h8000_0000, "min_neg");
    sweep("extreme_sweep");

    // Enable gating: clocked data with WriteEn=0 changes nothing
    @(negedge clk);
    addy       = 5'd5;
    write_data = 32'hDEAD_BEEF;
    write_en   = 1'b0;
    @(posedge clk);
    #1;
    read_chk(5'd5, "enable_gate");

    // Read latency: address changes between edges are seen immediately
    @(negedge clk);
    read_chk(5'd9,  "addr_follow_a");
    read_chk(5'd1,  "addr_follow_b");
    read_chk(5'd31, "addr_follow_c");

    // WriteData change at the same address shows only after the edge
    write_chk(5'd31, 32'h1234_5678, "data_at_edge");

    // Mid-operation reset: assert between edges, clear is immediate
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    read_chk(5'd31, "async_clear_now");

    // Hold reset over several edges with writes attempted
    write_en   = 1'b1;
    write_data = 32'hA5A5_A5A5;
    sweep("reset_override_sweep");
    write_en = 1'b0;

    // Release and write 7 to address 1; everything else stays zero
    @(negedge clk);
    rst_n = 1'b1;
    write_chk(5'd1, 32'd7, "post_reset_write");
    sweep("post_reset_sweep");

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_data_memory
`default_nettype wire
